// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked XLEN ALU with branch compare and jump passthrough.
// Define ALU_MULDIV_EN to add the M-extension multiplier and iterative divider.
module alu_seq #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5:0]      ALU_Control,
    input  logic [XLEN-1:0] operand_A,
    input  logic [XLEN-1:0] operand_B,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ALU_result,
    output logic            branch,
    output logic            busy
);
    localparam int SW = $clog2(XLEN);
    typedef enum logic [2:0] {IDLE, EXEC, MUL, DIV, DONE} state_t;
    state_t state, state_nx;
    logic accept, md, is_mul, is_div, mul_last, div_last, eq, lt, ltu, br;
    logic [1:0] cls;
    logic [2:0] f3;
    logic [SW-1:0] shamt;
    logic [XLEN-1:0] res, sra, mul_res, div_res;

    assign cls       = ALU_Control[4:3];
    assign f3        = ALU_Control[2:0];
    assign shamt     = operand_B[SW-1:0];
    assign is_mul    = md & (cls == 2'b00) & !f3[2];
    assign is_div    = md & (cls == 2'b00) & f3[2];
    assign out_valid = (state == EXEC) | (state == DONE);
    // The output register can be refilled in the same cycle it is consumed.
    assign in_ready  = (state != MUL) & (state != DIV) & (!out_valid | out_ready);
    assign accept    = in_valid & in_ready;
    assign eq        = operand_A == operand_B;
    assign lt        = $signed(operand_A) < $signed(operand_B);
    assign ltu       = operand_A < operand_B;
    assign sra       = $signed(operand_A) >>> shamt;

    always_comb begin
        res = '0;
        br  = 1'b0;
        if (md) res = (cls == 2'b00) ? mul_res : operand_A + operand_B;
        else case (cls)
            2'b00: case (f3)
                3'b000:  res = operand_A + operand_B;
                3'b001:  res = operand_A << shamt;
                3'b010:  res = {{(XLEN-1){1'b0}}, lt};
                3'b011:  res = {{(XLEN-1){1'b0}}, ltu};
                3'b100:  res = operand_A ^ operand_B;
                3'b101:  res = operand_A >> shamt;
                3'b110:  res = operand_A | operand_B;
                default: res = operand_A & operand_B;
            endcase
            2'b01: res = (f3 == 3'b000) ? operand_A - operand_B :
                         (f3 == 3'b001) ? operand_A << shamt :
                         (f3 == 3'b101) ? sra : '0;
            2'b10: begin
                br  = (f3 == 3'b000) ? eq  : (f3 == 3'b001) ? !eq  :
                      (f3 == 3'b100) ? lt  : (f3 == 3'b101) ? !lt  :
                      (f3 == 3'b110) ? ltu : (f3 == 3'b111) ? !ltu : 1'b0;
                res = {{(XLEN-1){1'b0}}, br};
            end
            default: res = {operand_A[XLEN-1:1], 1'b0};
        endcase
    end

    always_comb begin
        state_nx = state;
        if (out_valid && out_ready) state_nx = IDLE;
        if (mul_last) state_nx = EXEC;
        if (div_last) state_nx = DONE;
        if (accept) state_nx = is_div ? DIV : (is_mul && MUL_STAGES > 1) ? MUL : EXEC;
    end

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            state      <= IDLE;
            ALU_result <= '0;
            branch     <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                ALU_result <= res;
                branch     <= br;
            end else if (mul_last) ALU_result <= mul_res;
            else if (div_last) ALU_result <= div_res;
        end

`ifdef ALU_MULDIV_EN
    localparam int ML = (MUL_STAGES > 1) ? MUL_STAGES - 2 : 0;
    logic [XLEN-1:0] op_a, op_b, ma, mb, quo, rem, dvs, quo_nx, rem_nx;
    logic [1:0] fn, mf;
    logic [SW-1:0] cnt;
    logic neg_q, neg_r, dz, sgn, sa, sb;
    logic [2*XLEN-1:0] ea, eb, prod;
    logic [XLEN:0] sh, dif;

    assign md       = ALU_Control[5];
    assign busy     = (state == MUL) | (state == DIV);
    // A single-stage multiply works straight off the inputs; deeper ones use the captured copy.
    assign ma       = (state == MUL) ? op_a : operand_A;
    assign mb       = (state == MUL) ? op_b : operand_B;
    assign mf       = (state == MUL) ? fn : f3[1:0];
    assign ea       = {{XLEN{ma[XLEN-1] & (mf != 2'b11)}}, ma};
    assign eb       = {{XLEN{mb[XLEN-1] & (mf == 2'b01)}}, mb};
    assign prod     = ea * eb;
    assign mul_res  = (mf == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    assign mul_last = (state == MUL) && (cnt == SW'(ML));
    assign sgn      = !f3[0];
    assign sa       = sgn & operand_A[XLEN-1];
    assign sb       = sgn & operand_B[XLEN-1];
    // Restoring division on magnitudes; signs are reapplied on the final iteration.
    assign sh       = {rem, quo[XLEN-1]};
    assign dif      = sh - {1'b0, dvs};
    assign rem_nx   = dif[XLEN] ? sh[XLEN-1:0] : dif[XLEN-1:0];
    assign quo_nx   = {quo[XLEN-2:0], !dif[XLEN]};
    assign div_last = (state == DIV) && (cnt == SW'(XLEN - 1));
    assign div_res  = fn[1] ? (dz ? op_a : neg_r ? -rem_nx : rem_nx)
                            : (dz ? '1   : neg_q ? -quo_nx : quo_nx);

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            op_a  <= '0;
            op_b  <= '0;
            fn    <= '0;
            cnt   <= '0;
            quo   <= '0;
            rem   <= '0;
            dvs   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz    <= 1'b0;
        end else if (accept) begin
            op_a  <= operand_A;
            op_b  <= operand_B;
            fn    <= f3[1:0];
            cnt   <= '0;
            quo   <= sa ? -operand_A : operand_A;
            dvs   <= sb ? -operand_B : operand_B;
            rem   <= '0;
            neg_q <= sa ^ sb;
            neg_r <= sa;
            dz    <= operand_B == '0;
        end else begin
            if (busy) cnt <= cnt + 1'b1;
            if (state == DIV) begin
                quo <= quo_nx;
                rem <= rem_nx;
            end
        end
`else
    assign md       = ALU_Control[5] & 1'b0;
    assign busy     = 1'b0;
    assign mul_res  = '0;
    assign div_res  = '0;
    assign mul_last = 1'b0;
    assign div_last = 1'b0;
`endif
endmodule
